// File: rtl/coil_angle_driver.sv
// Ignition coil scheduler: charges the coil between two programmable crank angles
// taken from the angle generator, with a dwell-time limit and double-buffered config.
module coil_angle_driver #(
  parameter int ANGLE_W = 16,
  parameter int ANGLE_N = 3840,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_ena,
  input  logic               cfg_wr,
  input  logic [ANGLE_W-1:0] cfg_on,
  input  logic [ANGLE_W-1:0] cfg_off,
  input  logic [DWELL_W-1:0] cfg_max_dwell,
  input  logic               fault_clr,
  output logic               coil,
  output logic               spark,
  output logic               fault_dwell,
  output logic               cfg_err,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    CHARGE = 2'd2
  } state_t;

  localparam logic [ANGLE_W-1:0] LP_N  = ANGLE_W'(ANGLE_N);
  localparam logic [ANGLE_W:0]   LP_NX = (ANGLE_W+1)'(ANGLE_N);

  state_t             r_state;
  logic               r_coil;
  logic               r_spark;
  logic               r_fault;
  logic               r_cfgErr;
  logic [DWELL_W-1:0] r_dwell;
  logic [ANGLE_W-1:0] r_shOn;
  logic [ANGLE_W-1:0] r_shOff;
  logic [DWELL_W-1:0] r_shMax;
  logic               r_pending;
  logic [ANGLE_W-1:0] r_actOn;
  logic [ANGLE_W-1:0] r_actOff;
  logic [DWELL_W-1:0] r_actMax;
  logic [ANGLE_W-1:0] r_prevAngle;
  logic               r_prevValid;

  logic               w_cfgValid;
  logic [ANGLE_W-1:0] w_delta;
  logic [ANGLE_W-1:0] w_onRel;
  logic [ANGLE_W-1:0] w_offRel;
  logic               w_strobeOk;
  logic               w_onHit;
  logic               w_offHit;
  logic               w_dwellExpired;

  // Modular distance a - b on the ring 0..ANGLE_N-1, valid for any ANGLE_N.
  function automatic logic [ANGLE_W-1:0] modSub(input logic [ANGLE_W-1:0] a,
                                                input logic [ANGLE_W-1:0] b);
    logic [ANGLE_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[ANGLE_W]) diff = diff + LP_NX;
    return diff[ANGLE_W-1:0];
  endfunction

  assign w_cfgValid = (cfg_on < LP_N) && (cfg_off < LP_N);
  assign w_delta    = modSub(angle, r_prevAngle);
  assign w_onRel    = modSub(r_actOn, r_prevAngle);
  assign w_offRel   = modSub(r_actOff, r_prevAngle);
  assign w_strobeOk = angle_ena && r_prevValid && (w_delta != '0);
  assign w_onHit    = w_strobeOk && (w_onRel != '0) && (w_onRel <= w_delta);
  assign w_offHit   = w_strobeOk && (w_offRel != '0) && (w_offRel <= w_delta);
  assign w_dwellExpired = (r_actMax != '0) && (r_dwell == r_actMax - 1'b1);

  // Shadow/active config: the active copy never changes while a charge is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shOn    <= '0;
      r_shOff   <= '0;
      r_shMax   <= '0;
      r_pending <= 1'b0;
      r_actOn   <= '0;
      r_actOff  <= '0;
      r_actMax  <= '0;
      r_cfgErr  <= 1'b0;
    end else begin
      r_cfgErr <= cfg_wr && !w_cfgValid;
      if (r_pending && (r_state != CHARGE)) begin
        r_actOn   <= r_shOn;
        r_actOff  <= r_shOff;
        r_actMax  <= r_shMax;
        r_pending <= 1'b0;
      end
      if (cfg_wr && w_cfgValid) begin
        r_shOn    <= cfg_on;
        r_shOff   <= cfg_off;
        r_shMax   <= cfg_max_dwell;
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevAngle <= '0;
      r_prevValid <= 1'b0;
    end else begin
      if (angle_ena) r_prevAngle <= angle;
      if (!hwag_start)    r_prevValid <= 1'b0;
      else if (angle_ena) r_prevValid <= 1'b1;
    end
  end

  // Fault set below is assigned after the clear, so a coincident new fault wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_coil  <= 1'b0;
      r_spark <= 1'b0;
      r_fault <= 1'b0;
      r_dwell <= '0;
    end else begin
      r_spark <= 1'b0;
      if (fault_clr) r_fault <= 1'b0;
      if (!hwag_start) begin
        r_state <= IDLE;
        r_coil  <= 1'b0;
        r_dwell <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_coil  <= 1'b0;
            r_state <= ARMED;
          end
          ARMED: begin
            r_coil <= 1'b0;
            if (w_onHit && !w_offHit) begin
              r_state <= CHARGE;
              r_coil  <= 1'b1;
              r_dwell <= '0;
            end
          end
          CHARGE: begin
            if (r_dwell != '1) r_dwell <= r_dwell + 1'b1;
            if (w_offHit) begin
              r_state <= ARMED;
              r_coil  <= 1'b0;
              r_spark <= 1'b1;
            end else if (w_dwellExpired) begin
              r_state <= ARMED;
              r_coil  <= 1'b0;
              r_fault <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_coil  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign coil        = r_coil;
  assign spark       = r_spark;
  assign fault_dwell = r_fault;
  assign cfg_err     = r_cfgErr;
  assign state_o     = r_state;

endmodule

// File: tb/tb_coil_angle_driver.sv
// Bench for coil_angle_driver: stimulus pushes expected output events (with the cycle
// they must appear in) to a queue; a negedge monitor pops and compares observed events.
module tb_coil_angle_driver;

  localparam int ANGLE_W = 16;
  localparam int DWELL_W = 24;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_SPARK = 2;
  localparam int K_CERR  = 3;
  localparam int K_FSET  = 4;
  localparam int K_FCLR  = 5;

  localparam int M_RISE  = 1 << K_RISE;
  localparam int M_FALL  = 1 << K_FALL;
  localparam int M_SPARK = 1 << K_SPARK;
  localparam int M_CERR  = 1 << K_CERR;
  localparam int M_FSET  = 1 << K_FSET;
  localparam int M_FCLR  = 1 << K_FCLR;

  logic               clk = 1'b0;
  logic               rst;
  logic               hwag_start;
  logic [ANGLE_W-1:0] angle;
  logic               angle_ena;
  logic               cfg_wr;
  logic [ANGLE_W-1:0] cfg_on;
  logic [ANGLE_W-1:0] cfg_off;
  logic [DWELL_W-1:0] cfg_max_dwell;
  logic               fault_clr;
  logic               coil;
  logic               spark;
  logic               fault_dwell;
  logic               cfg_err;
  logic [1:0]         state_o;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t  expQ[$];
  int   cycCount = 0;
  int   lastEdge = 0;
  int   total = 0;
  int   bad = 0;
  bit   monEn = 1'b0;
  logic prevCoil = 1'b0;
  logic prevFault = 1'b0;

  coil_angle_driver #(.ANGLE_W(ANGLE_W), .ANGLE_N(3840), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .angle(angle), .angle_ena(angle_ena),
    .cfg_wr(cfg_wr), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_max_dwell(cfg_max_dwell),
    .fault_clr(fault_clr), .coil(coil), .spark(spark), .fault_dwell(fault_dwell),
    .cfg_err(cfg_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  function automatic string kindName(input int k);
    case (k)
      K_RISE:  return "coil_rise";
      K_FALL:  return "coil_fall";
      K_SPARK: return "spark";
      K_CERR:  return "cfg_err";
      K_FSET:  return "fault_set";
      default: return "fault_clear";
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic matchEvent(input int kind);
    ev_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_%s: seen at cycle %0d, none expected", kindName(kind), cycCount);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.cyc != cycCount) begin
        bad++;
        $display("[TB] FAIL event_%s: got %s at cycle %0d expected %s at cycle %0d",
                 kindName(e.kind), kindName(kind), cycCount, kindName(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: turns output transitions and pulses into events, in kind order.
  always @(negedge clk) begin
    if (monEn) begin
      if (coil && !prevCoil) matchEvent(K_RISE);
      if (!coil && prevCoil) matchEvent(K_FALL);
      if (spark) matchEvent(K_SPARK);
      if (cfg_err) matchEvent(K_CERR);
      if (fault_dwell && !prevFault) matchEvent(K_FSET);
      if (!fault_dwell && prevFault) matchEvent(K_FCLR);
      prevCoil = coil;
      prevFault = fault_dwell;
    end
  end

  task automatic pushMask(input int mask, input int edgeCyc);
    for (int k = 0; k < 6; k++) begin
      if (mask[k]) expQ.push_back('{kind: k, cyc: edgeCyc});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One angle strobe, then three quiet cycles; events in mask appear at the sampling edge.
  task automatic applyStimulus(input int a, input int mask);
    lastEdge = cycCount + 1;
    pushMask(mask, lastEdge);
    angle = ANGLE_W'(a);
    angle_ena = 1'b1;
    idle(1);
    angle_ena = 1'b0;
    idle(3);
  endtask

  task automatic cfgWrite(input int onA, input int offA, input int maxD, input int mask);
    pushMask(mask, cycCount + 1);
    cfg_on = ANGLE_W'(onA);
    cfg_off = ANGLE_W'(offA);
    cfg_max_dwell = DWELL_W'(maxD);
    cfg_wr = 1'b1;
    idle(1);
    cfg_wr = 1'b0;
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    hwag_start = 1'b0;
    angle = '0;
    angle_ena = 1'b0;
    cfg_wr = 1'b0;
    cfg_on = '0;
    cfg_off = '0;
    cfg_max_dwell = '0;
    fault_clr = 1'b0;
    idle(3);
    checkOutput("reset_coil", coil, 0);
    checkOutput("reset_spark", spark, 0);
    checkOutput("reset_fault", fault_dwell, 0);
    checkOutput("reset_cfg_err", cfg_err, 0);
    checkOutput("reset_state", state_o, 0);
    rst = 1'b0;
    prevCoil = coil;
    prevFault = fault_dwell;
    monEn = 1'b1;

    // Nominal charge
    cfgWrite(1000, 1200, 0, 0);
    hwag_start = 1'b1;
    idle(2);
    checkOutput("armed_after_sync", state_o, 1);
    for (int a = 990; a <= 1210; a++)
      applyStimulus(a, (a == 1000) ? M_RISE : (a == 1200) ? (M_FALL | M_SPARK) : 0);
    checkOutput("nominal_no_fault", fault_dwell, 0);

    // Wrap through ANGLE_N-1 -> 0
    cfgWrite(3800, 40, 0, 0);
    for (int a = 3790; a <= 3839; a++) applyStimulus(a, (a == 3800) ? M_RISE : 0);
    for (int a = 0; a <= 50; a++) applyStimulus(a, (a == 40) ? (M_FALL | M_SPARK) : 0);

    // Resync jump over both targets in one strobe
    cfgWrite(1000, 1003, 0, 0);
    applyStimulus(997, 0);
    applyStimulus(998, 0);
    applyStimulus(1005, 0);
    checkOutput("jump_both_state", state_o, 1);
    checkOutput("jump_both_coil", coil, 0);
    cfgWrite(1000, 1010, 0, 0);
    applyStimulus(997, 0);
    applyStimulus(998, 0);
    applyStimulus(1005, M_RISE);
    applyStimulus(1010, M_FALL | M_SPARK);

    // Dwell limit of 50 cycles
    cfgWrite(500, 600, 50, 0);
    applyStimulus(499, 0);
    applyStimulus(500, M_RISE);
    pushMask(M_FALL | M_FSET, lastEdge + 50);
    idle(60);
    checkOutput("dwell_state", state_o, 1);
    checkOutput("dwell_fault", fault_dwell, 1);
    pushMask(M_FCLR, cycCount + 1);
    fault_clr = 1'b1;
    idle(1);
    fault_clr = 1'b0;
    idle(2);

    // Deferred config during charge, then sync loss, then rejected write
    cfgWrite(1500, 1600, 0, 0);
    applyStimulus(1499, 0);
    applyStimulus(1500, M_RISE);
    cfgWrite(2000, 2100, 0, 0);
    checkOutput("deferred_coil_held", coil, 1);
    applyStimulus(1600, M_FALL | M_SPARK);
    applyStimulus(1999, 0);
    applyStimulus(2000, M_RISE);
    pushMask(M_FALL, cycCount + 1);
    hwag_start = 1'b0;
    idle(2);
    checkOutput("syncloss_state", state_o, 0);
    checkOutput("syncloss_coil", coil, 0);
    cfgWrite(3840, 100, 0, M_CERR);
    hwag_start = 1'b1;
    idle(2);
    applyStimulus(1990, 0);
    applyStimulus(2000, M_RISE);
    applyStimulus(2100, M_FALL | M_SPARK);

    idle(5);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
